// File: rtl/apb_buffered_bridge.sv
// apb_buffered_bridge
// Single-clock APB-to-APB bridge. Requests from the upstream (side A)
// slave port are queued in a small command FIFO and replayed in order by
// a full APB master on the downstream (side B) segment. Writes may
// complete upstream as soon as they are queued (posted). Reads, and
// writes when posting is disabled, hold the upstream transfer in wait
// states until the matching downstream completion returns its data and
// error status.

module apb_buffered_bridge #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4,
    parameter int POSTED_WR = 1
) (
    input  logic                     clk,
    input  logic                     rst,

    // upstream APB slave port
    input  logic [ADDR_W-1:0]        paddr_a,
    input  logic [DATA_W-1:0]        pwdata_a,
    input  logic                     pwrite_a,
    input  logic                     psel_a,
    input  logic                     penable_a,
    output logic [DATA_W-1:0]        prdata_a,
    output logic                     pready_a,
    output logic                     pslverr_a,

    // downstream APB master port
    output logic [ADDR_W-1:0]        paddr_b,
    output logic [DATA_W-1:0]        pwdata_b,
    output logic                     pwrite_b,
    output logic                     psel_b,
    output logic                     penable_b,
    input  logic [DATA_W-1:0]        prdata_b,
    input  logic                     pready_b,
    input  logic                     pslverr_b,

    // posted-write error reporting and queue status
    input  logic                     err_clr,
    output logic                     err_posted,
    output logic [$clog2(DEPTH):0]   cmd_level
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = 2 + ADDR_W + DATA_W;

    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    // upstream FSM states
    localparam logic [1:0] A_IDLE   = 2'd0;
    localparam logic [1:0] A_WAIT   = 2'd1;
    localparam logic [1:0] A_DONE   = 2'd2;

    // downstream FSM states
    localparam logic [1:0] B_IDLE   = 2'd0;
    localparam logic [1:0] B_SETUP  = 2'd1;
    localparam logic [1:0] B_ACCESS = 2'd2;

    // ------------------------------------------------------------------
    // command FIFO: circular buffer, pointers carry one extra wrap bit so
    // that equal indices can be told apart as either full or empty
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W:0]     wr_ptr;
    logic [PTR_W:0]     rd_ptr;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               push_need_rsp;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] pop_entry;

    logic [1:0]         a_state;
    logic [1:0]         b_state;
    logic               b_need_rsp;
    logic               b_complete;

    // Both flags come straight from registered pointers, so a slot freed
    // by a pop is only offered to side A on the following cycle.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign cmd_level  = wr_ptr - rd_ptr;

    // Reads always need the completion; writes need it only when posting
    // is disabled.
    assign push_need_rsp = !pwrite_a || (POSTED_WR == 0);
    assign push_entry    = {push_need_rsp, pwrite_a, paddr_a, pwdata_a};
    assign pop_entry     = fifo_mem[rd_ptr[PTR_W-1:0]];

    // A request is accepted only while side A is idle and space exists.
    assign push = (a_state == A_IDLE) && psel_a && penable_a && !fifo_full;

    // A downstream transfer finishes on the access cycle the slave is ready.
    assign b_complete = (b_state == B_ACCESS) && pready_b;

    // Side B takes the next command when idle or right as it finishes the
    // current one; an entry written this edge is not yet visible here.
    assign pop = !fifo_empty && ((b_state == B_IDLE) || b_complete);

    // Entry storage has no reset: only slots between the pointers matter.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= push_entry;
        end
    end

    // Write pointer advances on every accepted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
        end
    end

    // Read pointer advances whenever side B takes a command.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
        end else if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // ------------------------------------------------------------------
    // side A: accept, optionally wait for the downstream response, then
    // give exactly one ready cycle
    // ------------------------------------------------------------------

    // Upstream FSM with registered ready, read data and error.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_state   <= A_IDLE;
            pready_a  <= 1'b0;
            prdata_a  <= '0;
            pslverr_a <= 1'b0;
        end else begin
            case (a_state)
                A_IDLE: begin
                    pready_a  <= 1'b0;
                    prdata_a  <= '0;
                    pslverr_a <= 1'b0;
                    if (push) begin
                        if (push_need_rsp) begin
                            a_state <= A_WAIT;
                        end else begin
                            a_state  <= A_DONE;
                            pready_a <= 1'b1;
                        end
                    end
                end
                A_WAIT: begin
                    // Only one need_rsp command can be in flight, so the
                    // first such completion is the one being waited for.
                    if (b_complete && b_need_rsp) begin
                        a_state   <= A_DONE;
                        pready_a  <= 1'b1;
                        prdata_a  <= prdata_b;
                        pslverr_a <= pslverr_b;
                    end
                end
                A_DONE: begin
                    a_state   <= A_IDLE;
                    pready_a  <= 1'b0;
                    prdata_a  <= '0;
                    pslverr_a <= 1'b0;
                end
                default: begin
                    a_state   <= A_IDLE;
                    pready_a  <= 1'b0;
                    prdata_a  <= '0;
                    pslverr_a <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // side B: APB master replaying queued commands in order
    // ------------------------------------------------------------------

    // Downstream FSM; all bus outputs are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_state    <= B_IDLE;
            psel_b     <= 1'b0;
            penable_b  <= 1'b0;
            paddr_b    <= '0;
            pwdata_b   <= '0;
            pwrite_b   <= 1'b0;
            b_need_rsp <= 1'b0;
        end else begin
            case (b_state)
                B_IDLE: begin
                    psel_b    <= 1'b0;
                    penable_b <= 1'b0;
                    if (pop) begin
                        b_state    <= B_SETUP;
                        psel_b     <= 1'b1;
                        b_need_rsp <= pop_entry[ENTRY_W-1];
                        pwrite_b   <= pop_entry[ENTRY_W-2];
                        paddr_b    <= pop_entry[DATA_W +: ADDR_W];
                        pwdata_b   <= pop_entry[DATA_W-1:0];
                    end
                end
                B_SETUP: begin
                    b_state   <= B_ACCESS;
                    psel_b    <= 1'b1;
                    penable_b <= 1'b1;
                end
                B_ACCESS: begin
                    if (pready_b) begin
                        if (pop) begin
                            // back-to-back: select stays high into the
                            // next setup phase
                            b_state    <= B_SETUP;
                            psel_b     <= 1'b1;
                            penable_b  <= 1'b0;
                            b_need_rsp <= pop_entry[ENTRY_W-1];
                            pwrite_b   <= pop_entry[ENTRY_W-2];
                            paddr_b    <= pop_entry[DATA_W +: ADDR_W];
                            pwdata_b   <= pop_entry[DATA_W-1:0];
                        end else begin
                            b_state   <= B_IDLE;
                            psel_b    <= 1'b0;
                            penable_b <= 1'b0;
                        end
                    end
                end
                default: begin
                    b_state   <= B_IDLE;
                    psel_b    <= 1'b0;
                    penable_b <= 1'b0;
                end
            endcase
        end
    end

    // Sticky flag for errors on writes nobody upstream is waiting for; a
    // new error in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_posted <= 1'b0;
        end else if (b_complete && pwrite_b && !b_need_rsp && pslverr_b) begin
            err_posted <= 1'b1;
        end else if (err_clr) begin
            err_posted <= 1'b0;
        end
    end

endmodule

// File: tb/tb_apb_buffered_bridge.sv
// tb_apb_buffered_bridge
// Directed bench for apb_buffered_bridge. The main instance uses posted
// writes with a downstream memory model whose wait states, error response
// and read-data override are set per test. A second instance with posting
// disabled checks that writes then wait for downstream completion.

module tb_apb_buffered_bridge;

    logic        clk = 1'b0;
    logic        rst;

    logic [31:0] paddr_a, pwdata_a;
    logic        pwrite_a, penable_a, psel_drv, sel_np;
    logic        psel_a, psel_np;
    logic [31:0] prdata_a;
    logic        pready_a, pslverr_a;

    logic [31:0] paddr_b, pwdata_b;
    logic        pwrite_b, psel_b, penable_b;
    logic [31:0] prdata_b;
    logic        pready_b, pslverr_b;
    logic        err_clr, err_posted;
    logic [2:0]  cmd_level;

    logic [31:0] np_prdata_a, np_paddr_b, np_pwdata_b;
    logic        np_pready_a, np_pslverr_a, np_pwrite_b, np_psel_b, np_penable_b;
    logic        np_err_posted;
    logic [2:0]  np_cmd_level;

    logic        ready_sel;

    int          compared = 0;
    int          mismatched = 0;

    int          wait_states;
    int          acc_cnt;
    logic        hold_b, err_b, ovr_en;
    logic [31:0] ovr_data;
    logic [31:0] mem [256];

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
    } xfer_t;
    xfer_t       seen [$];
    xfer_t       mon_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          ws;
        logic        errb;
        logic        ovr;
        logic [31:0] ovr_data;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;
    vec_t        vecs [10];

    always #5 clk = ~clk;

    assign psel_a    = psel_drv && !sel_np;
    assign psel_np   = psel_drv && sel_np;
    assign ready_sel = sel_np ? np_pready_a : pready_a;

    // downstream slave model: memory with configurable wait states
    assign pready_b  = psel_b && penable_b && !hold_b && (acc_cnt >= wait_states);
    assign pslverr_b = err_b;
    assign prdata_b  = ovr_en ? ovr_data : mem[paddr_b[7:0]];

    apb_buffered_bridge #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .POSTED_WR(1)) dut (
        .clk(clk), .rst(rst),
        .paddr_a(paddr_a), .pwdata_a(pwdata_a), .pwrite_a(pwrite_a),
        .psel_a(psel_a), .penable_a(penable_a),
        .prdata_a(prdata_a), .pready_a(pready_a), .pslverr_a(pslverr_a),
        .paddr_b(paddr_b), .pwdata_b(pwdata_b), .pwrite_b(pwrite_b),
        .psel_b(psel_b), .penable_b(penable_b),
        .prdata_b(prdata_b), .pready_b(pready_b), .pslverr_b(pslverr_b),
        .err_clr(err_clr), .err_posted(err_posted), .cmd_level(cmd_level)
    );

    apb_buffered_bridge #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .POSTED_WR(0)) dut_np (
        .clk(clk), .rst(rst),
        .paddr_a(paddr_a), .pwdata_a(pwdata_a), .pwrite_a(pwrite_a),
        .psel_a(psel_np), .penable_a(penable_a),
        .prdata_a(np_prdata_a), .pready_a(np_pready_a), .pslverr_a(np_pslverr_a),
        .paddr_b(np_paddr_b), .pwdata_b(np_pwdata_b), .pwrite_b(np_pwrite_b),
        .psel_b(np_psel_b), .penable_b(np_penable_b),
        .prdata_b(32'h0), .pready_b(1'b1), .pslverr_b(1'b0),
        .err_clr(1'b0), .err_posted(np_err_posted), .cmd_level(np_cmd_level)
    );

    // count cycles spent in the access phase to insert wait states
    always @(posedge clk) begin
        if (psel_b && penable_b && !pready_b) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    // record every completed downstream transfer and update the memory
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (psel_b && penable_b && pready_b) begin
            mon_t.w = pwrite_b;
            mon_t.a = paddr_b;
            mon_t.d = pwrite_b ? pwdata_b : prdata_b;
            seen.push_back(mon_t);
            if (pwrite_b) mem[paddr_b[7:0]] <= pwdata_b;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // one complete upstream transfer; lat counts cycles from the first
    // access cycle (cycle 0) to the cycle where ready is seen
    task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                                 input logic [31:0] data, output logic [31:0] rdata,
                                 output logic err, output int lat);
        psel_drv  = 1'b1;
        penable_a = 1'b0;
        pwrite_a  = wr;
        paddr_a   = addr;
        pwdata_a  = data;
        @(posedge clk); #1;
        penable_a = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!ready_sel && lat < 50);
        rdata = sel_np ? np_prdata_a : prdata_a;
        err   = sel_np ? np_pslverr_a : pslverr_a;
        @(posedge clk); #1;
        psel_drv  = 1'b0;
        penable_a = 1'b0;
    endtask

    task automatic drainB(input string name);
        int n = 0;
        while ((cmd_level != 0 || psel_b) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput(name, 64'(n < 100), 64'd1);
    endtask

    // global time bound
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          base;
        int          n;
        int          stall_hits;

        rst = 1'b1; psel_drv = 1'b0; sel_np = 1'b0; penable_a = 1'b0;
        pwrite_a = 1'b0; paddr_a = '0; pwdata_a = '0; err_clr = 1'b0;
        hold_b = 1'b0; err_b = 1'b0; ovr_en = 1'b0; ovr_data = '0; wait_states = 0;

        vecs[0] = '{1'b1, 32'h20, 32'h1234_5678, 0, 1'b0, 1'b0, 32'h0, 32'h0,         1'b0, 1};
        vecs[1] = '{1'b0, 32'h20, 32'h0,         0, 1'b0, 1'b0, 32'h0, 32'h1234_5678, 1'b0, 4};
        vecs[2] = '{1'b0, 32'h20, 32'h0,         2, 1'b0, 1'b0, 32'h0, 32'h1234_5678, 1'b0, 6};
        vecs[3] = '{1'b1, 32'h24, 32'hFFFF_FFFF, 1, 1'b0, 1'b0, 32'h0, 32'h0,         1'b0, 1};
        vecs[4] = '{1'b0, 32'h24, 32'h0,         1, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF, 1'b0, 5};
        vecs[5] = '{1'b0, 32'h30, 32'h0,         3, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 7};
        vecs[6] = '{1'b0, 32'h20, 32'h0,         0, 1'b0, 1'b0, 32'h0, 32'h1234_5678, 1'b0, 4};
        vecs[7] = '{1'b0, 32'h10, 32'h0,         0, 1'b0, 1'b0, 32'h0, 32'hA5A5_0001, 1'b0, 4};
        vecs[8] = '{1'b1, 32'h30, 32'hCAFE_F00D, 2, 1'b0, 1'b0, 32'h0, 32'h0,         1'b0, 1};
        vecs[9] = '{1'b0, 32'h30, 32'h0,         0, 1'b0, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0, 4};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset side A", {prdata_a, pready_a, pslverr_a}, 64'd0);
        checkOutput("reset side B ctrl", {psel_b, penable_b, pwrite_b}, 64'd0);
        checkOutput("reset side B addr", paddr_b, 64'd0);
        checkOutput("reset side B wdata", pwdata_b, 64'd0);
        checkOutput("reset status", {err_posted, cmd_level}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // posted write followed straight away by a read of the same address
        base = seen.size();
        applyStimulus(1'b1, 32'h10, 32'hA5A5_0001, rd, er, lat);
        checkOutput("wr latency", lat, 64'd1);
        checkOutput("wr pslverr_a", er, 64'd0);
        applyStimulus(1'b0, 32'h10, 32'h0, rd, er, lat);
        checkOutput("rd latency", lat, 64'd4);
        checkOutput("rd data", rd, 64'hA5A5_0001);
        drainB("drain order");
        checkOutput("order count", seen.size() - base, 64'd2);
        if (seen.size() >= base + 2) begin
            checkOutput("order first", {seen[base].w, seen[base].a, seen[base].d},
                        {1'b1, 32'h10, 32'hA5A5_0001});
            checkOutput("order second", {seen[base+1].w, seen[base+1].a},
                        {1'b0, 32'h10});
        end

        // table of single transfers with wait states / errors
        for (int i = 0; i < 10; i++) begin
            wait_states = vecs[i].ws;
            err_b       = vecs[i].errb;
            ovr_en      = vecs[i].ovr;
            ovr_data    = vecs[i].ovr_data;
            applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].data, rd, er, lat);
            checkOutput($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
            checkOutput($sformatf("vec%0d pslverr", i), er, vecs[i].exp_err);
            checkOutput($sformatf("vec%0d latency", i), lat, 64'(vecs[i].exp_lat));
            drainB($sformatf("vec%0d drain", i));
            err_b = 1'b0; ovr_en = 1'b0; wait_states = 0;
        end
        checkOutput("err_posted after reads", err_posted, 64'd0);

        // posted write answered with an error, then cleared
        err_b = 1'b1;
        applyStimulus(1'b1, 32'h40, 32'h55, rd, er, lat);
        checkOutput("posted err pslverr_a", er, 64'd0);
        checkOutput("posted err latency", lat, 64'd1);
        drainB("posted err drain");
        err_b = 1'b0;
        checkOutput("err_posted set", err_posted, 64'd1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        checkOutput("err_posted cleared", err_posted, 64'd0);

        // stalled downstream: fill the FIFO, next request must wait
        hold_b = 1'b1;
        base = seen.size();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 32'h80 + 32'(4*i), 32'h1000 + 32'(i), rd, er, lat);
            checkOutput($sformatf("fill%0d latency", i), lat, 64'd1);
        end
        checkOutput("full cmd_level", cmd_level, 64'd4);
        psel_drv = 1'b1; penable_a = 1'b0; pwrite_a = 1'b1;
        paddr_a = 32'h94; pwdata_a = 32'h1005;
        @(posedge clk); #1;
        penable_a = 1'b1;
        stall_hits = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (pready_a) stall_hits++;
        end
        checkOutput("stall pready_a", stall_hits, 64'd0);
        hold_b = 1'b0;
        @(posedge clk); #1;
        hold_b = 1'b1;
        n = 0;
        while (!pready_a && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("stall released", pready_a, 64'd1);
        @(posedge clk); #1;
        psel_drv = 1'b0; penable_a = 1'b0;
        hold_b = 1'b0;
        drainB("stall drain");
        checkOutput("stall count", seen.size() - base, 64'd6);
        if (seen.size() >= base + 6) begin
            for (int i = 0; i < 6; i++) begin
                checkOutput($sformatf("stall xfer%0d", i),
                            {seen[base+i].w, seen[base+i].a, seen[base+i].d},
                            {1'b1, 32'h80 + 32'(4*i), 32'h1000 + 32'(i)});
            end
        end

        // non-posted instance: write waits for downstream completion
        sel_np = 1'b1;
        applyStimulus(1'b1, 32'h50, 32'h77, rd, er, lat);
        checkOutput("nonposted latency", lat, 64'd4);
        checkOutput("nonposted pslverr_a", er, 64'd0);
        @(posedge clk); #1;
        checkOutput("nonposted status", {np_err_posted, np_cmd_level, np_psel_b}, 64'd0);
        sel_np = 1'b0;

        // reset while side B is mid-access with two commands queued
        hold_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'hC0 + 32'(4*i), 32'h2000 + 32'(i), rd, er, lat);
        end
        checkOutput("pre-reset cmd_level", cmd_level, 64'd2);
        checkOutput("pre-reset access", {psel_b, penable_b}, 64'd3);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("reset psel_b", {psel_b, penable_b}, 64'd0);
        checkOutput("reset cmd_level", cmd_level, 64'd0);
        checkOutput("reset pready_a", pready_a, 64'd0);
        rst = 1'b0;
        hold_b = 1'b0;
        base = seen.size();
        repeat (10) @(posedge clk);
        #1;
        checkOutput("no stale transfer", seen.size() - base, 64'd0);
        checkOutput("no stale psel_b", psel_b, 64'd0);

        // bridge is usable again after reset (memory model was cleared)
        applyStimulus(1'b0, 32'hC0, 32'h0, rd, er, lat);
        checkOutput("post-reset rd data", rd, 64'd0);
        checkOutput("post-reset rd latency", lat, 64'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
